// File: rtl/fb_scan_reader_pkg.sv
// Shared types and constants for the frame-buffer scan-out path.
// Pixel formats, display modes, swap FSM states and the colour-bar palette.
package fb_scan_reader_pkg;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef enum logic [1:0] {
        MODE_FB    = 2'b00,
        MODE_BARS  = 2'b01,
        MODE_GRID  = 2'b10,
        MODE_BLACK = 2'b11
    } fb_mode_e;

    typedef enum logic {
        SWAP_IDLE    = 1'b0,
        SWAP_PENDING = 1'b1
    } swap_state_e;

    // Left to right: white, yellow, cyan, green, magenta, red, blue, black.
    localparam logic [23:0] BAR_COLOURS [0:7] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    // Replicate the top bits so full-scale 565 maps to full-scale 888.
    function automatic logic [23:0] rgb565_to_888(input rgb565_t p);
        return {p.r, p.r[4:2], p.g, p.g[5:4], p.b, p.b[4:2]};
    endfunction

endpackage

// File: rtl/fb_scan_reader_if.sv
// Read port between the scan reader and the frame-buffer block RAM.
interface fb_scan_reader_if #(
    parameter int ADDR_W = 17
);
    logic [ADDR_W-1:0] fb_addr_out;
    logic [15:0]       fb_data_in;

    modport master (output fb_addr_out, input fb_data_in);
    modport slave  (input fb_addr_out, output fb_data_in);
endinterface

// File: rtl/fb_scan_reader_pipe_delay.sv
// Fixed-depth shift register that clears on reset; keeps side data aligned with memory reads.
module pipe_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [DEPTH-1:0][WIDTH-1:0] stage_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            stage_reg <= '0;
        end else begin
            stage_reg[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_reg[i] <= stage_reg[i-1];
            end
        end
    end

    assign dout = stage_reg[DEPTH-1];
endmodule

// File: rtl/fb_scan_reader.sv
// Scans a double-buffered downscaled RGB565 frame buffer in raster order and emits RGB888
// with realigned sync; optional test patterns; buffer swaps only on the new-frame pulse.
module fb_scan_reader
    import fb_scan_reader_pkg::*;
#(
    parameter int ACTIVE_H_PIXELS = 1280,
    parameter int ACTIVE_LINES    = 720,
    parameter int H_COUNT_W       = 11,
    parameter int V_COUNT_W       = 10,
    parameter int SCALE_LOG2      = 2,
    parameter int READ_LATENCY    = 2
) (
    input  logic                 pixel_clk_in,
    input  logic                 rst_in,
    input  logic [H_COUNT_W-1:0] hcount_in,
    input  logic [V_COUNT_W-1:0] vcount_in,
    input  logic                 hs_in,
    input  logic                 vs_in,
    input  logic                 ad_in,
    input  logic                 nf_in,
    input  logic [1:0]           mode_in,
    input  logic                 swap_req_in,
    output logic                 swap_ack_out,
    output logic                 front_buf_out,
    fb_scan_reader_if.master     fb_bus,
    output logic [7:0]           red_out,
    output logic [7:0]           green_out,
    output logic [7:0]           blue_out,
    output logic                 hs_out,
    output logic                 vs_out,
    output logic                 ad_out
);
    localparam int FB_W   = ACTIVE_H_PIXELS >> SCALE_LOG2;
    localparam int FB_H   = ACTIVE_LINES >> SCALE_LOG2;
    localparam int ADDR_W = $clog2(2 * FB_W * FB_H);
    localparam int BAR_W  = ACTIVE_H_PIXELS / 8;
    localparam int SIDE_W = 3 + 1 + 24;
    localparam logic [ADDR_W-1:0] BACK_BASE = ADDR_W'(FB_W * FB_H);

    swap_state_e swap_state_reg;
    fb_mode_e    mode_q;
    logic        front_buf_reg;
    logic        swap_ack_reg;

    logic [ADDR_W-1:0] base, row_addr, col_addr, addr_next;
    logic [6:0]        past_edge;
    logic [2:0]        bar_idx;
    logic [23:0]       pat_rgb;
    logic              use_fb;
    logic [SIDE_W-1:0] side_next, side_dly;

    assign base      = front_buf_reg ? BACK_BASE : '0;
    assign row_addr  = ADDR_W'(vcount_in >> SCALE_LOG2) * ADDR_W'(FB_W);
    assign col_addr  = ADDR_W'(hcount_in >> SCALE_LOG2);
    assign addr_next = ad_in ? (base + row_addr + col_addr) : base;

    // Bar index = number of bar boundaries already passed.
    for (genvar gi = 0; gi < 7; gi++) begin : g_bar_edge
        assign past_edge[gi] = (hcount_in >= H_COUNT_W'((gi + 1) * BAR_W));
    end
    assign bar_idx = 3'($countones(past_edge));

    always_comb begin
        pat_rgb = '0;
        use_fb  = 1'b0;
        case (mode_q)
            MODE_FB:   use_fb  = 1'b1;
            MODE_BARS: pat_rgb = BAR_COLOURS[bar_idx];
            MODE_GRID: begin
                if (hcount_in[4:0] == 5'd0 || vcount_in[4:0] == 5'd0) begin
                    pat_rgb = 24'hFFFFFF;
                end
            end
            default: ;
        endcase
    end

    // Address and pattern are both launched now; the memory answer arrives READ_LATENCY later.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            swap_state_reg     <= SWAP_IDLE;
            front_buf_reg      <= 1'b0;
            swap_ack_reg       <= 1'b0;
            mode_q             <= MODE_FB;
            fb_bus.fb_addr_out <= '0;
        end else begin
            fb_bus.fb_addr_out <= addr_next;
            swap_ack_reg       <= 1'b0;
            if (nf_in) begin
                mode_q <= fb_mode_e'(mode_in);
            end
            case (swap_state_reg)
                SWAP_IDLE: begin
                    if (swap_req_in && nf_in) begin
                        front_buf_reg <= ~front_buf_reg;
                        swap_ack_reg  <= 1'b1;
                    end else if (swap_req_in) begin
                        swap_state_reg <= SWAP_PENDING;
                    end
                end
                SWAP_PENDING: begin
                    if (nf_in) begin
                        front_buf_reg  <= ~front_buf_reg;
                        swap_ack_reg   <= 1'b1;
                        swap_state_reg <= SWAP_IDLE;
                    end
                end
                default: swap_state_reg <= SWAP_IDLE;
            endcase
        end
    end

    assign swap_ack_out  = swap_ack_reg;
    assign front_buf_out = front_buf_reg;

    assign side_next = {hs_in, vs_in, ad_in, use_fb, pat_rgb};

    pipe_delay #(
        .WIDTH (SIDE_W),
        .DEPTH (READ_LATENCY + 1)
    ) u_side_delay (
        .clk  (pixel_clk_in),
        .srst (rst_in),
        .din  (side_next),
        .dout (side_dly)
    );

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            {red_out, green_out, blue_out} <= '0;
            hs_out <= 1'b0;
            vs_out <= 1'b0;
            ad_out <= 1'b0;
        end else begin
            hs_out <= side_dly[27];
            vs_out <= side_dly[26];
            ad_out <= side_dly[25];
            if (!side_dly[25]) begin
                {red_out, green_out, blue_out} <= '0;
            end else if (side_dly[24]) begin
                {red_out, green_out, blue_out} <= rgb565_to_888(rgb565_t'(fb_bus.fb_data_in));
            end else begin
                {red_out, green_out, blue_out} <= side_dly[23:0];
            end
        end
    end

endmodule

// File: tb/tb_fb_scan_reader.sv
// Randomised and directed checks of fb_scan_reader against a frame-level reference model.
module tb_fb_scan_reader;
    localparam int FB_SIZE = 57600;

    typedef struct packed {
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
        logic        ad;
    } vid_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [10:0] hc;
    logic [9:0]  vc;
    logic        hs, vs, ad, nf, swap_req;
    logic [1:0]  mode;
    logic        swap_ack, front_buf;
    logic [7:0]  r_o, g_o, b_o;
    logic        hs_o, vs_o, ad_o;
    logic        check_en = 1'b0;

    int checks = 0;
    int errors = 0;

    fb_scan_reader_if #(.ADDR_W(17)) fb_bus();

    fb_scan_reader dut (
        .pixel_clk_in  (clk),
        .rst_in        (rst),
        .hcount_in     (hc),
        .vcount_in     (vc),
        .hs_in         (hs),
        .vs_in         (vs),
        .ad_in         (ad),
        .nf_in         (nf),
        .mode_in       (mode),
        .swap_req_in   (swap_req),
        .swap_ack_out  (swap_ack),
        .front_buf_out (front_buf),
        .fb_bus        (fb_bus),
        .red_out       (r_o),
        .green_out     (g_o),
        .blue_out      (b_o),
        .hs_out        (hs_o),
        .vs_out        (vs_o),
        .ad_out        (ad_o)
    );

    // Two-cycle registered block RAM.
    logic [15:0] mem [0:2*FB_SIZE-1];
    logic [16:0] bram_addr_reg;
    always @(posedge clk) begin
        bram_addr_reg      <= fb_bus.fb_addr_out;
        fb_bus.fb_data_in  <= mem[bram_addr_reg];
    end

    // ---------------- reference model ----------------
    function automatic int calc_addr(input logic front, input int h, input int v, input logic a);
        int base = front ? FB_SIZE : 0;
        if (!a) return base;
        return base + (v / 4) * 320 + (h / 4);
    endfunction

    function automatic logic [23:0] expand(input logic [15:0] p);
        int r = int'(p[15:11]);
        int g = int'(p[10:5]);
        int b = int'(p[4:0]);
        return {8'((r << 3) | (r >> 2)), 8'((g << 2) | (g >> 4)), 8'((b << 3) | (b >> 2))};
    endfunction

    function automatic logic [23:0] bar_colour(input int h);
        case (h / 160)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic vid_t model_pixel(input logic [1:0] m, input logic front, input int h,
                                         input int v, input logic a, input logic s_h, input logic s_v);
        vid_t o;
        o.hs = s_h;
        o.vs = s_v;
        o.ad = a;
        o.rgb = 24'h0;
        if (a) begin
            case (m)
                2'b00: o.rgb = expand(mem[calc_addr(front, h, v, a)]);
                2'b01: o.rgb = bar_colour(h);
                2'b10: o.rgb = ((h % 32) == 0 || (v % 32) == 0) ? 24'hFFFFFF : 24'h000000;
                default: o.rgb = 24'h0;
            endcase
        end
        return o;
    endfunction

    vid_t        out_q[$];
    logic        m_front, m_pending;
    logic [1:0]  m_mode;
    logic [16:0] exp_addr;
    logic        exp_ack, exp_front;
    vid_t        exp_vid;

    always @(posedge clk) begin
        if (rst) begin
            m_front   <= 1'b0;
            m_pending <= 1'b0;
            m_mode    <= 2'b00;
            exp_addr  <= '0;
            exp_ack   <= 1'b0;
            exp_front <= 1'b0;
            exp_vid   <= '0;
            out_q.delete();
            out_q.push_back(vid_t'(0));
            out_q.push_back(vid_t'(0));
            out_q.push_back(vid_t'(0));
        end else begin
            exp_addr <= 17'(calc_addr(m_front, int'(hc), int'(vc), ad));
            out_q.push_back(model_pixel(m_mode, m_front, int'(hc), int'(vc), ad, hs, vs));
            exp_vid <= out_q.pop_front();
            if (nf) m_mode <= mode;
            if (nf && (m_pending || swap_req)) begin
                m_front   <= ~m_front;
                exp_front <= ~m_front;
                exp_ack   <= 1'b1;
                m_pending <= 1'b0;
            end else begin
                exp_front <= m_front;
                exp_ack   <= 1'b0;
                if (swap_req) m_pending <= 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            check("model_addr", 32'(fb_bus.fb_addr_out), 32'(exp_addr));
            check("model_front", 32'(front_buf), 32'(exp_front));
            check("model_ack", 32'(swap_ack), 32'(exp_ack));
            check("model_rgb", 32'({r_o, g_o, b_o}), 32'(exp_vid.rgb));
            check("model_sync", 32'({hs_o, vs_o, ad_o}), 32'({exp_vid.hs, exp_vid.vs, exp_vid.ad}));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        hc = 11'($urandom_range(0, 2047));
        vc = 10'($urandom_range(0, 1023));
        hs = 1'b0; vs = 1'b0; ad = 1'b0; nf = 1'b0; swap_req = 1'b0;
    endtask

    task automatic pix_check(input int h, input int v, input logic [23:0] req, input string name);
        hc = 11'(h); vc = 10'(v); ad = 1'b1; nf = 1'b0; swap_req = 1'b0;
        tick();
        idle();
        repeat (3) tick();
        check(name, 32'({r_o, g_o, b_o}), 32'(req));
        $display("pixel h=%0d v=%0d rgb=%06h", h, v, {r_o, g_o, b_o});
    endtask

    initial begin
        for (int i = 0; i < 2 * FB_SIZE; i++) mem[i] = 16'($urandom);
        mem[641] = 16'hF800;
        rst = 1'b1; mode = 2'b00;
        idle();

        // Reset with busy inputs.
        @(posedge clk);
        check_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_rgb", 32'({r_o, g_o, b_o}), 32'h0);
            check("rst_addr", 32'(fb_bus.fb_addr_out), 32'h0);
            check("rst_flags", 32'({swap_ack, front_buf, hs_o, vs_o, ad_o}), 32'h0);
            hc = 11'($urandom); vc = 10'($urandom); ad = 1'b1;
            hs = ~hs; vs = ~vs; nf = ~nf; swap_req = ~swap_req; mode = 2'($urandom);
            $display("reset cycle %0d outputs idle", i);
        end
        rst = 1'b0;
        idle();
        mode = 2'b00;

        // Single framebuffer pixel through the read latency.
        hc = 11'd7; vc = 10'd9; ad = 1'b1;
        tick();
        check("addr_7_9", 32'(fb_bus.fb_addr_out), 32'd641);
        idle();
        repeat (3) tick();
        check("rgb_f800", 32'({r_o, g_o, b_o}), 32'hFF0000);
        check("ad_lat4", 32'(ad_o), 32'd1);
        $display("fb pixel addr=641 rgb=%02h%02h%02h", r_o, g_o, b_o);

        // Swap waits for the frame boundary.
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        check("no_early_swap", 32'({swap_ack, front_buf}), 32'h0);
        repeat (3) tick();
        check("still_front0", 32'(front_buf), 32'd0);
        hc = 11'd0; vc = 10'd0; ad = 1'b1; nf = 1'b1;
        tick();
        check("swap_ack", 32'({swap_ack, front_buf}), 32'h3);
        nf = 1'b0;
        tick();
        check("addr_back_0_0", 32'(fb_bus.fb_addr_out), 32'd57600);
        check("ack_one_cycle", 32'(swap_ack), 32'd0);
        $display("swap at nf front=%0d", front_buf);

        // Blanking uses the base address and keeps sync.
        hc = 11'd500; vc = 10'd300; ad = 1'b0; hs = 1'b1;
        tick();
        check("blank_addr", 32'(fb_bus.fb_addr_out), 32'd57600);
        idle();
        repeat (3) tick();
        check("blank_rgb", 32'({r_o, g_o, b_o}), 32'h0);
        check("blank_hs", 32'({hs_o, ad_o}), 32'h2);
        $display("blanking hs_out=%0d", hs_o);

        // Request coincident with nf swaps immediately.
        swap_req = 1'b1; nf = 1'b1;
        tick();
        check("swap_now", 32'({swap_ack, front_buf}), 32'h2);
        idle();
        tick();
        $display("coincident swap front=%0d", front_buf);

        // Mode latched only at nf.
        mode = 2'b01; nf = 1'b1;
        tick();
        idle();
        pix_check(0, 5, 24'hFFFFFF, "bar0");
        pix_check(160, 5, 24'hFFFF00, "bar1");
        pix_check(1279, 5, 24'h000000, "bar7");
        mode = 2'b10;
        pix_check(160, 5, 24'hFFFF00, "mode_held");
        nf = 1'b1;
        tick();
        idle();
        pix_check(160, 5, 24'hFFFFFF, "grid_col");
        pix_check(161, 5, 24'h000000, "grid_off");
        pix_check(161, 64, 24'hFFFFFF, "grid_row");

        // Reset drops a pending swap.
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0; rst = 1'b1;
        repeat (2) tick();
        check("rst_front", 32'(front_buf), 32'd0);
        rst = 1'b0; nf = 1'b1;
        tick();
        check("no_ack_after_rst", 32'({swap_ack, front_buf}), 32'h0);
        idle();
        $display("pending swap cleared by reset");

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            tick();
            rst = ($urandom_range(0, 299) == 0);
            ad  = ($urandom_range(0, 3) != 0);
            hc  = ad ? 11'($urandom_range(0, 1279)) : 11'($urandom);
            vc  = ad ? 10'($urandom_range(0, 719)) : 10'($urandom);
            hs  = 1'($urandom); vs = 1'($urandom);
            nf  = ($urandom_range(0, 15) == 0);
            swap_req = ($urandom_range(0, 7) == 0);
            mode = 2'($urandom);
        end
        rst = 1'b0;
        idle();
        repeat (6) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
